// File: rtl/mem_stage_ctrl.sv
// MEM-stage controller: executes loads/stores against the data memory over a
// req/ready handshake, stalls the EX/MEM register while an access is pending,
// and aborts accesses that are never acknowledged within TIMEOUT cycles.
module mem_stage_ctrl #(
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        ex_valid,
  input  logic        ex_load,
  input  logic        ex_store,
  input  logic [15:0] ex_mem_addr,
  input  logic [2:0]  ex_rdest_addr,
  input  logic [15:0] ex_rdest_data,
  output logic        EXtoMEM_Wen,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [15:0] dmem_addr,
  output logic [15:0] dmem_wdata,
  input  logic        dmem_ready,
  input  logic [15:0] dmem_rdata,
  output logic        wb_valid,
  output logic        wb_wen,
  output logic [2:0]  wb_rdest_addr,
  output logic [15:0] wb_rdest_data,
  output logic        mem_err
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  // Counter value on which a still-unacknowledged access is abandoned.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             we_q, we_nxt;
  logic [15:0]      addr_q, addr_nxt;
  logic [15:0]      wdata_q, wdata_nxt;
  logic [2:0]       rd_q, rd_nxt;
  logic             wbv_nxt, wbwen_nxt, err_nxt;
  logic [2:0]       wbaddr_nxt;
  logic [15:0]      wbdata_nxt;

  // Request fields come straight from the latched access; they hold their
  // last value while no request is outstanding.
  assign dmem_we    = we_q;
  assign dmem_addr  = addr_q;
  assign dmem_wdata = wdata_q;

  // Next-state, next-register values and state-decoded handshake outputs.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    we_nxt      = we_q;
    addr_nxt    = addr_q;
    wdata_nxt   = wdata_q;
    rd_nxt      = rd_q;
    wbv_nxt     = 1'b0;
    wbwen_nxt   = wb_wen;
    wbaddr_nxt  = wb_rdest_addr;
    wbdata_nxt  = wb_rdest_data;
    err_nxt     = 1'b0;
    EXtoMEM_Wen = 1'b1;
    dmem_req    = 1'b0;

    case (state)
      IDLE: begin
        if (ex_valid) begin
          if (ex_load || ex_store) begin
            // Store wins if both flags are set.
            we_nxt    = ex_store;
            addr_nxt  = ex_mem_addr;
            wdata_nxt = ex_rdest_data;
            rd_nxt    = ex_rdest_addr;
            cnt_nxt   = '0;
            state_nxt = BUSY;
          end else begin
            wbv_nxt    = 1'b1;
            wbwen_nxt  = 1'b1;
            wbaddr_nxt = ex_rdest_addr;
            wbdata_nxt = ex_rdest_data;
          end
        end
      end
      BUSY: begin
        EXtoMEM_Wen = 1'b0;
        dmem_req    = 1'b1;
        if (dmem_ready) begin
          // Completion takes precedence over a simultaneous timeout.
          state_nxt = IDLE;
          wbv_nxt   = 1'b1;
          if (we_q) begin
            wbwen_nxt = 1'b0;
          end else begin
            wbwen_nxt  = 1'b1;
            wbaddr_nxt = rd_q;
            wbdata_nxt = dmem_rdata;
          end
        end else if (cnt == CNT_LAST) begin
          state_nxt = IDLE;
          err_nxt   = 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, latched access and MEM/WB result registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state         <= IDLE;
      cnt           <= '0;
      we_q          <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      rd_q          <= '0;
      wb_valid      <= 1'b0;
      wb_wen        <= 1'b0;
      wb_rdest_addr <= '0;
      wb_rdest_data <= '0;
      mem_err       <= 1'b0;
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      we_q          <= we_nxt;
      addr_q        <= addr_nxt;
      wdata_q       <= wdata_nxt;
      rd_q          <= rd_nxt;
      wb_valid      <= wbv_nxt;
      wb_wen        <= wbwen_nxt;
      wb_rdest_addr <= wbaddr_nxt;
      wb_rdest_data <= wbdata_nxt;
      mem_err       <= err_nxt;
    end
  end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed bench for mem_stage_ctrl: ALU pass-through, load, store,
// timeout abort, ready on the timeout edge, and reset during an access.
module tb_mem_stage_ctrl;

  logic        clk = 1'b0;
  logic        resetn;
  logic        ex_valid, ex_load, ex_store;
  logic [15:0] ex_mem_addr;
  logic [2:0]  ex_rdest_addr;
  logic [15:0] ex_rdest_data;
  logic        EXtoMEM_Wen, dmem_req, dmem_we;
  logic [15:0] dmem_addr, dmem_wdata;
  logic        dmem_ready;
  logic [15:0] dmem_rdata;
  logic        wb_valid, wb_wen;
  logic [2:0]  wb_rdest_addr;
  logic [15:0] wb_rdest_data;
  logic        mem_err;

  int checks = 0;
  int errors = 0;
  int n;

  mem_stage_ctrl #(.TIMEOUT(15), .CNT_W(4)) dut (
    .clk(clk), .resetn(resetn),
    .ex_valid(ex_valid), .ex_load(ex_load), .ex_store(ex_store),
    .ex_mem_addr(ex_mem_addr), .ex_rdest_addr(ex_rdest_addr),
    .ex_rdest_data(ex_rdest_data),
    .EXtoMEM_Wen(EXtoMEM_Wen), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
    .wb_valid(wb_valid), .wb_wen(wb_wen), .wb_rdest_addr(wb_rdest_addr),
    .wb_rdest_data(wb_rdest_data), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic ex_drive(input logic v, input logic ld, input logic st,
                          input logic [15:0] a, input logic [2:0] rd, input logic [15:0] d);
    ex_valid = v; ex_load = ld; ex_store = st;
    ex_mem_addr = a; ex_rdest_addr = rd; ex_rdest_data = d;
  endtask

  task automatic chk_reset_vals(input string pfx);
    chk({pfx, "_wen"},    EXtoMEM_Wen, 1);
    chk({pfx, "_req"},    dmem_req, 0);
    chk({pfx, "_we"},     dmem_we, 0);
    chk({pfx, "_addr"},   dmem_addr, 0);
    chk({pfx, "_wdata"},  dmem_wdata, 0);
    chk({pfx, "_wbv"},    wb_valid, 0);
    chk({pfx, "_wbwen"},  wb_wen, 0);
    chk({pfx, "_wbaddr"}, wb_rdest_addr, 0);
    chk({pfx, "_wbdata"}, wb_rdest_data, 0);
    chk({pfx, "_err"},    mem_err, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn = 1'b0;
    dmem_ready = 1'b0; dmem_rdata = 16'h0;
    ex_drive(0, 0, 0, 16'h0, 3'd0, 16'h0);
    repeat (2) @(negedge clk);
    chk_reset_vals("rst");
    resetn = 1'b1;
    @(negedge clk);

    // Three back-to-back ALU ops
    ex_drive(1, 0, 0, 16'h0, 3'd1, 16'h1234);
    @(negedge clk);
    chk("alu1_v", wb_valid, 1); chk("alu1_wen", wb_wen, 1);
    chk("alu1_a", wb_rdest_addr, 1); chk("alu1_d", wb_rdest_data, 16'h1234);
    chk("alu1_stall", EXtoMEM_Wen, 1);
    ex_drive(1, 0, 0, 16'h0, 3'd2, 16'hBEEF);
    @(negedge clk);
    chk("alu2_v", wb_valid, 1); chk("alu2_a", wb_rdest_addr, 2);
    chk("alu2_d", wb_rdest_data, 16'hBEEF); chk("alu2_stall", EXtoMEM_Wen, 1);
    ex_drive(1, 0, 0, 16'h0, 3'd7, 16'hFFFF);
    @(negedge clk);
    chk("alu3_v", wb_valid, 1); chk("alu3_wen", wb_wen, 1);
    chk("alu3_a", wb_rdest_addr, 7); chk("alu3_d", wb_rdest_data, 16'hFFFF);
    chk("alu3_stall", EXtoMEM_Wen, 1);
    ex_drive(0, 0, 0, 16'h0, 3'd0, 16'h0);
    @(negedge clk);
    chk("bubble_v", wb_valid, 0);

    // Load r3 from 0x0040, ready after 3 request cycles
    ex_drive(1, 1, 0, 16'h0040, 3'd3, 16'h0);
    @(negedge clk);
    ex_drive(0, 0, 0, 16'h0, 3'd0, 16'h0);
    for (int j = 1; j <= 3; j++) begin
      chk("ld_req", dmem_req, 1); chk("ld_we", dmem_we, 0);
      chk("ld_addr", dmem_addr, 16'h0040); chk("ld_stall", EXtoMEM_Wen, 0);
      chk("ld_wbv_busy", wb_valid, 0);
      if (j == 3) begin dmem_ready = 1'b1; dmem_rdata = 16'hA5A5; end
      @(negedge clk);
    end
    dmem_ready = 1'b0; dmem_rdata = 16'h0;
    chk("ld_req_done", dmem_req, 0); chk("ld_stall_done", EXtoMEM_Wen, 1);
    chk("ld_wbv", wb_valid, 1); chk("ld_wbwen", wb_wen, 1);
    chk("ld_wba", wb_rdest_addr, 3); chk("ld_wbd", wb_rdest_data, 16'hA5A5);

    // Store 0x5A5A to 0x0100 (load flag also set: store wins), then ALU r4
    ex_drive(1, 1, 1, 16'h0100, 3'd6, 16'h5A5A);
    @(negedge clk);
    chk("st_req", dmem_req, 1); chk("st_we", dmem_we, 1);
    chk("st_addr", dmem_addr, 16'h0100); chk("st_wdata", dmem_wdata, 16'h5A5A);
    chk("st_stall", EXtoMEM_Wen, 0);
    ex_drive(1, 0, 0, 16'h0, 3'd4, 16'h4444);
    dmem_ready = 1'b1;
    @(negedge clk);
    dmem_ready = 1'b0;
    chk("st_req_done", dmem_req, 0); chk("st_wbv", wb_valid, 1);
    chk("st_wbwen", wb_wen, 0); chk("st_stall_done", EXtoMEM_Wen, 1);
    @(negedge clk);
    chk("r4_v", wb_valid, 1); chk("r4_wen", wb_wen, 1);
    chk("r4_a", wb_rdest_addr, 4); chk("r4_d", wb_rdest_data, 16'h4444);
    ex_drive(0, 0, 0, 16'h0, 3'd0, 16'h0);
    @(negedge clk);
    chk("r4_once", wb_valid, 0);

    // Load with no ready: timeout abort, then ALU r6 proceeds
    ex_drive(1, 1, 0, 16'h0200, 3'd5, 16'h0);
    @(negedge clk);
    ex_drive(1, 0, 0, 16'h0, 3'd6, 16'h6666);
    n = 0;
    while (dmem_req && n < 40) begin
      chk("to_wbv_busy", wb_valid, 0); chk("to_err_busy", mem_err, 0);
      n++;
      @(negedge clk);
    end
    chk("to_req_cycles", n, 15);
    chk("to_err", mem_err, 1); chk("to_wbv", wb_valid, 0);
    chk("to_stall_done", EXtoMEM_Wen, 1);
    @(negedge clk);
    chk("to_err_pulse", mem_err, 0); chk("r6_v", wb_valid, 1);
    chk("r6_a", wb_rdest_addr, 6); chk("r6_d", wb_rdest_data, 16'h6666);
    ex_drive(0, 0, 0, 16'h0, 3'd0, 16'h0);
    @(negedge clk);

    // Ready on the exact timeout edge: completion wins
    ex_drive(1, 1, 0, 16'h0300, 3'd2, 16'h0);
    @(negedge clk);
    ex_drive(0, 0, 0, 16'h0, 3'd0, 16'h0);
    for (int j = 1; j <= 15; j++) begin
      chk("edge_req", dmem_req, 1);
      if (j == 15) begin dmem_ready = 1'b1; dmem_rdata = 16'h1357; end
      @(negedge clk);
    end
    dmem_ready = 1'b0;
    chk("edge_err", mem_err, 0); chk("edge_wbv", wb_valid, 1);
    chk("edge_wba", wb_rdest_addr, 2); chk("edge_wbd", wb_rdest_data, 16'h1357);
    chk("edge_req_done", dmem_req, 0);

    // Reset asserted during a store access
    ex_drive(1, 0, 1, 16'h0400, 3'd1, 16'hDEAD);
    @(negedge clk);
    chk("rs_req", dmem_req, 1);
    ex_drive(0, 0, 0, 16'h0, 3'd0, 16'h0);
    #2 resetn = 1'b0;
    #1;
    chk("rs_req_drop", dmem_req, 0); chk("rs_stall_drop", EXtoMEM_Wen, 1);
    @(negedge clk);
    resetn = 1'b1;
    dmem_ready = 1'b1;
    @(negedge clk);
    chk_reset_vals("post_rst");
    @(negedge clk);
    chk("post_rst_wbv", wb_valid, 0); chk("post_rst_err", mem_err, 0);
    chk("post_rst_req", dmem_req, 0);
    dmem_ready = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
